// File: rtl/sha256_digest_matcher.sv
// SHA-256 digest matcher: latches each finished digest on the rising edge of
// the adder's done level, compares it one 32-bit word per cycle against a
// software-loaded target, counts candidates and reports a sticky hit.
module sha256_digest_matcher #(
    parameter int unsigned CAND_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tgt_we,
    input  logic [2:0]        i_tgt_addr,
    input  logic [31:0]       i_tgt_word,
    input  logic              i_arm,
    input  logic              i_disarm,
    input  logic [255:0]      i_digest_in,
    input  logic              i_digest_valid,
    output logic              o_armed,
    output logic              o_match,
    output logic              o_found,
    output logic [CAND_W-1:0] o_found_idx,
    output logic [CAND_W-1:0] o_checked_count,
    output logic              o_overrun
);

    typedef enum logic [1:0] {StIdle, StArmed, StCmp, StFound} state_e;

    state_e              r_state;
    state_e              w_state_next;

    logic [31:0]         r_target [8];
    logic [255:0]        r_digest;
    logic                r_valid_q;
    logic [2:0]          r_word_idx;
    logic [CAND_W-1:0]   r_cand;
    logic [CAND_W-1:0]   r_count;
    logic [CAND_W-1:0]   r_found_idx;
    logic                r_found;
    logic                r_match;
    logic                r_overrun;

    logic                w_event;
    logic [31:0]         w_dig_word;
    logic                w_word_eq;
    logic [CAND_W-1:0]   w_count_sat_inc;
    logic                w_clear;
    logic                w_latch;
    logic                w_count_inc;
    logic                w_set_found;
    logic                w_set_overrun;

    // Rising edge of the done level is the only thing that starts a compare.
    assign w_event = i_digest_valid & ~r_valid_q;

    // Word 0 (H0) sits in the top bits, so ~idx selects the 32-bit lane.
    assign w_dig_word = r_digest[{~r_word_idx, 5'b0} +: 32];
    assign w_word_eq  = (w_dig_word == r_target[r_word_idx]);

    // Counter saturates so candidate numbering never wraps back onto old ones.
    assign w_count_sat_inc = (&r_count) ? r_count
                                        : r_count + {{(CAND_W-1){1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and the per-cycle update strobes for the datapath.
    always_comb begin
        w_state_next  = r_state;
        w_clear       = 1'b0;
        w_latch       = 1'b0;
        w_count_inc   = 1'b0;
        w_set_found   = 1'b0;
        w_set_overrun = 1'b0;
        if (i_disarm) begin
            // Abandons any in-flight compare without counting it.
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_arm) begin
                        w_clear      = 1'b1;
                        w_state_next = StArmed;
                    end
                end
                StArmed: begin
                    if (w_event) begin
                        w_latch      = 1'b1;
                        w_state_next = StCmp;
                    end
                end
                StCmp: begin
                    // A new digest while busy is dropped and flagged.
                    w_set_overrun = w_event;
                    if (!w_word_eq) begin
                        w_count_inc  = 1'b1;
                        w_state_next = StArmed;
                    end else if (r_word_idx == 3'd7) begin
                        w_count_inc  = 1'b1;
                        w_set_found  = 1'b1;
                        w_state_next = StFound;
                    end
                end
                StFound: begin
                    w_state_next = StFound;
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    // Datapath: target file, digest latch, counters and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_target[i] <= '0;
            end
            r_digest    <= '0;
            r_valid_q   <= 1'b0;
            r_word_idx  <= '0;
            r_cand      <= '0;
            r_count     <= '0;
            r_found_idx <= '0;
            r_found     <= 1'b0;
            r_match     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_valid_q <= i_digest_valid;
            r_match   <= w_set_found;
            if (r_state == StIdle && i_tgt_we) begin
                r_target[i_tgt_addr] <= i_tgt_word;
            end
            if (w_clear) begin
                r_found     <= 1'b0;
                r_found_idx <= '0;
                r_count     <= '0;
                r_overrun   <= 1'b0;
            end
            if (w_latch) begin
                r_digest   <= i_digest_in;
                r_word_idx <= '0;
                r_cand     <= r_count;
            end else if (r_state == StCmp) begin
                r_word_idx <= r_word_idx + 3'd1;
            end
            if (w_count_inc) begin
                r_count <= w_count_sat_inc;
            end
            if (w_set_found) begin
                r_found     <= 1'b1;
                r_found_idx <= r_cand;
            end
            if (w_set_overrun) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_armed         = (r_state != StIdle);
    assign o_match         = r_match;
    assign o_found         = r_found;
    assign o_found_idx     = r_found_idx;
    assign o_checked_count = r_count;
    assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_sha256_digest_matcher.sv
// Bench for sha256_digest_matcher: two instances (default width and a 4-bit
// counter) share all stimulus and are checked against a transaction-level model.
module tb_sha256_digest_matcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         tgt_we;
    logic [2:0]   tgt_addr;
    logic [31:0]  tgt_word;
    logic         arm;
    logic         disarm;
    logic [255:0] digest_in;
    logic         digest_valid;

    logic         a_armed, a_match, a_found, a_overrun;
    logic [31:0]  a_fidx, a_cnt;
    logic         b_armed, b_match, b_found, b_overrun;
    logic [3:0]   b_fidx, b_cnt;

    sha256_digest_matcher dut_a (
        .clk             (clk),
        .rst             (rst),
        .i_tgt_we        (tgt_we),
        .i_tgt_addr      (tgt_addr),
        .i_tgt_word      (tgt_word),
        .i_arm           (arm),
        .i_disarm        (disarm),
        .i_digest_in     (digest_in),
        .i_digest_valid  (digest_valid),
        .o_armed         (a_armed),
        .o_match         (a_match),
        .o_found         (a_found),
        .o_found_idx     (a_fidx),
        .o_checked_count (a_cnt),
        .o_overrun       (a_overrun)
    );

    sha256_digest_matcher #(.CAND_W(4)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .i_tgt_we        (tgt_we),
        .i_tgt_addr      (tgt_addr),
        .i_tgt_word      (tgt_word),
        .i_arm           (arm),
        .i_disarm        (disarm),
        .i_digest_in     (digest_in),
        .i_digest_valid  (digest_valid),
        .o_armed         (b_armed),
        .o_match         (b_match),
        .o_found         (b_found),
        .o_found_idx     (b_fidx),
        .o_checked_count (b_cnt),
        .o_overrun       (b_overrun)
    );

    localparam logic [255:0] ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: raw (unbounded) candidate count, saturated on compare.
    logic [31:0] m_tgt [8];
    longint      m_cnt;
    longint      m_fidx;
    bit          m_found;
    bit          m_ovr;
    bit          m_armed;

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit exp_match);
        chk({tag, "/a_armed"},   64'(a_armed),   64'(m_armed));
        chk({tag, "/a_match"},   64'(a_match),   64'(exp_match));
        chk({tag, "/a_found"},   64'(a_found),   64'(m_found));
        chk({tag, "/a_idx"},     64'(a_fidx),    64'(sat(m_fidx, 32)));
        chk({tag, "/a_cnt"},     64'(a_cnt),     64'(sat(m_cnt, 32)));
        chk({tag, "/a_overrun"}, 64'(a_overrun), 64'(m_ovr));
        chk({tag, "/b_armed"},   64'(b_armed),   64'(m_armed));
        chk({tag, "/b_match"},   64'(b_match),   64'(exp_match));
        chk({tag, "/b_found"},   64'(b_found),   64'(m_found));
        chk({tag, "/b_idx"},     64'(b_fidx),    64'(sat(m_fidx, 4)));
        chk({tag, "/b_cnt"},     64'(b_cnt),     64'(sat(m_cnt, 4)));
        chk({tag, "/b_overrun"}, 64'(b_overrun), 64'(m_ovr));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_tgt[i] = '0;
        m_cnt = 0; m_fidx = 0; m_found = 0; m_ovr = 0; m_armed = 0;
    endtask

    // Index of the first word that differs from the target, 8 for a full match.
    function automatic int first_miss(input logic [255:0] d);
        for (int k = 0; k < 8; k++) begin
            if (d[255-32*k -: 32] !== m_tgt[k]) return k;
        end
        return 8;
    endfunction

    // Digest equal to the target up to word k, wrong at word k, random after.
    function automatic logic [255:0] make_miss(input int k);
        logic [255:0] d;
        logic [31:0]  x;
        d = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < k) begin
                d[255-32*j -: 32] = m_tgt[j];
            end else if (j == k) begin
                x = $urandom;
                if (x == 0) x = 32'h1;
                d[255-32*j -: 32] = m_tgt[j] ^ x;
            end else begin
                d[255-32*j -: 32] = $urandom;
            end
        end
        return d;
    endfunction

    task automatic tgt_write(input logic [2:0] a, input logic [31:0] w);
        tgt_we = 1'b1; tgt_addr = a; tgt_word = w;
        tick();
        tgt_we = 1'b0;
        if (!m_armed) m_tgt[a] = w;
    endtask

    task automatic do_arm(input string tag);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        m_cnt = 0; m_fidx = 0; m_found = 0; m_ovr = 0; m_armed = 1;
        check_all(tag, 1'b0);
    endtask

    task automatic do_disarm(input string tag);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        m_armed = 0;
        check_all(tag, 1'b0);
    endtask

    // One digest while ARMED; the result must land exactly k+1 (or 8) edges
    // after the sampling edge and not one edge earlier.
    task automatic send(input string tag, input logic [255:0] d, input int hold);
        int     k;
        int     lat;
        longint ev;
        k   = first_miss(d);
        lat = (k == 8) ? 8 : k + 1;
        digest_in    = d;
        digest_valid = 1'b1;
        tick();
        ev = m_cnt;
        if (hold <= 1) digest_valid = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            tick();
            if (i + 1 >= hold) digest_valid = 1'b0;
            if (i == lat - 1) check_all({tag, "/pre"}, 1'b0);
            if (i == lat) begin
                m_cnt++;
                if (k == 8) begin
                    m_found = 1;
                    m_fidx  = ev;
                end
                check_all({tag, "/done"}, k == 8);
            end
        end
        digest_valid = 1'b0;
        tick();
        check_all({tag, "/after"}, 1'b0);
    endtask

    initial begin
        rst = 1'b0; tgt_we = 1'b0; tgt_addr = '0; tgt_word = '0;
        arm = 1'b0; disarm = 1'b0; digest_in = '0; digest_valid = 1'b0;
        model_reset();
        repeat (3) tick();
        check_all("reset", 1'b0);
        rst = 1'b1;
        tick();

        // Exact match after three misses.
        for (int w = 0; w < 8; w++) begin
            logic [255:0] t;
            t = ABC;
            tgt_write(3'(w), t[255-32*w -: 32]);
        end
        do_arm("arm1");
        for (int n = 0; n < 3; n++) send("miss1", make_miss($urandom_range(0, 7)), 1);
        send("abc1", ABC, 1);
        chk("abc1_idx", 64'(a_fidx), 64'd3);
        chk("abc1_cnt", 64'(a_cnt), 64'd4);

        // Disarm retains results; arm+disarm together stays idle; re-arm clears.
        do_disarm("disarm1");
        arm = 1'b1; disarm = 1'b1;
        tick();
        arm = 1'b0; disarm = 1'b0;
        check_all("arm_and_disarm", 1'b0);
        do_arm("arm2");

        // Early exit, late miss, level held for five cycles, locked target.
        send("early", ABC ^ (256'h1 << 224), 1);
        send("late", ABC ^ 256'h1, 1);
        send("level", make_miss(7), 5);
        tgt_write(3'd0, 32'hdeadbeef);
        for (int n = 0; n < 3; n++) send("miss2", make_miss($urandom_range(0, 7)), 1);
        send("abc2", ABC, 1);

        // Events in FOUND change nothing and do not flag overrun.
        for (int n = 0; n < 2; n++) begin
            digest_in = make_miss(7); digest_valid = 1'b1;
            tick();
            digest_valid = 1'b0;
            repeat (9) tick();
            check_all("found_hold", 1'b0);
        end
        do_disarm("disarm2");

        // Overrun: second rising edge three cycles into an 8-word compare.
        do_arm("arm3");
        digest_in = make_miss(7); digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        tick();
        tick();
        digest_in = ABC; digest_valid = 1'b1;
        tick();
        m_ovr = 1;
        check_all("ovr_set", 1'b0);
        digest_valid = 1'b0;
        repeat (4) tick();
        check_all("ovr_pre", 1'b0);
        tick();
        m_cnt++;
        check_all("ovr_done", 1'b0);
        tick();
        check_all("ovr_after", 1'b0);
        do_disarm("disarm3");

        // Arm taken while the level is already high: no event until it re-rises.
        digest_in = ABC; digest_valid = 1'b1;
        tick();
        tick();
        do_arm("arm_lvl");
        repeat (3) tick();
        check_all("arm_lvl_wait", 1'b0);
        digest_valid = 1'b0;
        tick();
        send("arm_lvl_abc", ABC, 1);
        do_disarm("disarm4");

        // Saturation of the narrow counter and candidate numbering past it.
        do_arm("arm_sat");
        for (int n = 0; n < 17; n++) send("sat_miss", make_miss($urandom_range(0, 7)), 1);
        chk("sat_b_cnt", 64'(b_cnt), 64'd15);
        send("sat_abc", ABC, 1);
        do_disarm("disarm5");

        // Reset during a compare clears everything, including the target.
        do_arm("arm_rst");
        digest_in = make_miss(7); digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        model_reset();
        check_all("rst_mid", 1'b0);
        rst = 1'b1;
        tick();
        do_arm("arm_zero");
        send("zero_tgt", 256'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
